merge_sched: RTL
================

Name: merge_sched

Overview:
- Sequencer in front of map_merger. For each output pixel it pulls one 64-bit word from each of three source streams in fixed order: 3x3 psum, 1x1 psum, then identity map (optional).
- Forwards the words over one registered valid/ready stream with a source tag and a last-of-pixel flag.
- Configured per layer by a start pulse and pixel count; reports busy/done to the top-level controller.

Parameters:
- DW, 64, data width of every source and of the output stream
- CW, 16, width of the pixel counter and cfg_pix_num

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  one-cycle pulse, begins a layer
- cfg_pix_num  in  CW  pixels in the layer, sampled on cfg_start
- cfg_id_en  in  1  1 = include identity word per pixel, sampled on cfg_start
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse, layer complete
- c3_data  in  DW  3x3 psum word
- c3_vld  in  1  3x3 psum valid
- c3_rdy  out  1  3x3 psum ready
- c1_data  in  DW  1x1 psum word
- c1_vld  in  1  1x1 psum valid
- c1_rdy  out  1  1x1 psum ready
- id_data  in  DW  identity word
- id_vld  in  1  identity valid
- id_rdy  out  1  identity ready
- mm_data  out  DW  word to map_merger
- mm_tag  out  2  0 = 3x3, 1 = 1x1, 2 = identity
- mm_last  out  1  last word of the current pixel
- mm_vld  out  1  output valid
- mm_rdy  in  1  map_merger ready

Behaviour:
- Reset (async, rst=1): state IDLE; pixel counter 0; cfg regs 0.
  - Outputs: busy=0, done=0, mm_vld=0, mm_data=0, mm_tag=0, mm_last=0, all *_rdy=0.
  - Reset mid-layer abandons the layer: no done pulse, output register is cleared.
- States: IDLE, S3, S1, SID, FIN.
- IDLE:
  - cfg_start=1 latches cfg_pix_num and cfg_id_en and clears the counter.
  - If cfg_pix_num==0, go to FIN; otherwise go to S3.
  - cfg_start in any other state is ignored.
- Output register:
  - "free" = !mm_vld || mm_rdy.
  - Only the source selected by the state may be ready: c3_rdy = (S3 && free), c1_rdy = (S1 && free), id_rdy = (SID && free). The other ready outputs are 0.
- Transfer:
  - A transfer is src_vld && src_rdy.
  - On the clock edge after a transfer: mm_data = src data, mm_tag = source code, mm_vld = 1.
  - mm_last = 1 for the 1x1 word when cfg_id_en=0, and for the identity word when cfg_id_en=1; otherwise 0.
  - Source-to-output latency is 1 cycle. Full throughput is 1 word/cycle while mm_rdy=1.
- Drain: when mm_vld && mm_rdy and there is no new transfer the same cycle, mm_vld goes to 0. mm_data/mm_tag/mm_last keep their last value.
- Stall: while mm_vld && !mm_rdy, mm_data/tag/last are held stable and no source is ready.
- Transitions (all on a transfer only):
  - S3 -> S1.
  - S1 -> SID if cfg_id_en=1; otherwise end-of-pixel.
  - SID -> end-of-pixel.
- End-of-pixel:
  - Counter increments.
  - If the counter reaches cfg_pix_num, go to FIN; otherwise go to S3.
- FIN:
  - Wait until the output register is empty, or is emptying this cycle (mm_vld=0, or mm_vld && mm_rdy).
  - Then done=1 for exactly one cycle and go to IDLE.
- busy = (state != IDLE).
- Ordering: source valids arriving out of turn are never accepted. An upstream producer with a valid word for a later source simply waits.
- Counter wraps are impossible: the layer ends at cfg_pix_num, which is at most 2^CW-1.

Test Plan:
- pix_num=2, id_en=1, all vld=1, mm_rdy=1 -> 6 output beats on consecutive cycles, tags 0,1,2,0,1,2, mm_last on beats 3 and 6, done 1 cycle after the last beat is accepted, busy 1 throughout.
- pix_num=3, id_en=0 -> 6 beats, tags 0,1 repeating, mm_last on every tag-1 beat, id_rdy never asserted.
- Backpressure: mm_rdy toggled 0/1 every cycle, pix_num=1, id_en=1 -> data/tag held stable while stalled, no beat lost or duplicated, at most one ready high in any cycle.
- Out-of-order valids: c1_vld and id_vld high, c3_vld low for 5 cycles -> no output and no ready on c1/id; raise c3_vld -> sequence resumes with tag 0.
- pix_num=0 -> no beats, done one cycle after FIN entry; cfg_start during busy -> ignored, beat count unchanged.
- rst asserted mid-pixel (after the tag-0 beat) -> busy, mm_vld and all ready outputs 0 immediately; next cfg_start restarts cleanly from tag 0.

Source files
------------

// File: rtl/merge_sched.sv
// merge_sched: orders 3x3 psum, 1x1 psum and optional identity words per
// pixel onto one registered valid/ready stream feeding map_merger.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_start              one-cycle pulse that begins a layer
//   cfg_pix_num            pixels in the layer (sampled on cfg_start)
//   cfg_id_en              1 = add an identity word per pixel (sampled on cfg_start)
//   busy, done             layer in progress / one-cycle completion pulse
//   c3_*, c1_*, id_*       source streams (data, vld in; rdy out)
//   mm_data/tag/last/vld   registered output stream to map_merger
//   mm_rdy                 map_merger ready
module merge_sched #(
    parameter int DW = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [CW-1:0] cfg_pix_num,
    input  logic          cfg_id_en,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] c3_data,
    input  logic          c3_vld,
    output logic          c3_rdy,
    input  logic [DW-1:0] c1_data,
    input  logic          c1_vld,
    output logic          c1_rdy,
    input  logic [DW-1:0] id_data,
    input  logic          id_vld,
    output logic          id_rdy,
    output logic [DW-1:0] mm_data,
    output logic [1:0]    mm_tag,
    output logic          mm_last,
    output logic          mm_vld,
    input  logic          mm_rdy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S3   = 3'd1,
        S1   = 3'd2,
        SID  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [1:0] TAG_C3 = 2'd0;
    localparam logic [1:0] TAG_C1 = 2'd1;
    localparam logic [1:0] TAG_ID = 2'd2;

    state_t        state_q;
    logic [CW-1:0] pix_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          id_en_q;
    logic [DW-1:0] data_q;
    logic [1:0]    tag_q;
    logic          last_q;
    logic          vld_q;
    logic          done_q;

    logic          free;
    logic          xfer;
    logic          pix_end;
    logic [DW-1:0] src_data;
    logic [1:0]    src_tag;
    logic          src_last;

    // Output register can take a new word when empty or emptying now.
    assign free   = !vld_q || mm_rdy;
    assign c3_rdy = (state_q == S3) && free;
    assign c1_rdy = (state_q == S1) && free;
    assign id_rdy = (state_q == SID) && free;

    // Source mux: only the source owned by the current state can transfer.
    always_comb begin
        xfer     = 1'b0;
        src_data = '0;
        src_tag  = TAG_C3;
        src_last = 1'b0;
        unique case (state_q)
            S3: begin
                xfer     = c3_vld && c3_rdy;
                src_data = c3_data;
            end
            S1: begin
                xfer     = c1_vld && c1_rdy;
                src_data = c1_data;
                src_tag  = TAG_C1;
                src_last = !id_en_q;
            end
            SID: begin
                xfer     = id_vld && id_rdy;
                src_data = id_data;
                src_tag  = TAG_ID;
                src_last = 1'b1;
            end
            default: ;
        endcase
    end

    // The word flagged last is exactly the one that closes the pixel.
    assign pix_end = xfer && src_last;
    assign cnt_d   = cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            cnt_q   <= '0;
            id_en_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= TAG_C3;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (xfer) begin
                data_q <= src_data;
                tag_q  <= src_tag;
                last_q <= src_last;
                vld_q  <= 1'b1;
            end else if (vld_q && mm_rdy) begin
                vld_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        pix_q   <= cfg_pix_num;
                        id_en_q <= cfg_id_en;
                        cnt_q   <= '0;
                        state_q <= (cfg_pix_num == '0) ? FIN : S3;
                    end
                end
                S3: begin
                    if (xfer) state_q <= S1;
                end
                S1, SID: begin
                    if (pix_end) begin
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_d == pix_q) ? FIN : S3;
                    end else if (xfer) begin
                        state_q <= SID;
                    end
                end
                FIN: begin
                    // Hold done until the final word has left the register.
                    if (free) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign mm_data = data_q;
    assign mm_tag  = tag_q;
    assign mm_last = last_q;
    assign mm_vld  = vld_q;

endmodule
